// File: rtl/em4100_framer.sv
// EM4100-style 64-bit frame serialiser: header, row-parity data rows, column parity, stop bit.
// Build option: EM4100_FRAMER_REPEAT_EN makes the block retransmit the latched ID back-to-back forever.
module em4100_framer #(
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [39:0] id_data,
  input  logic        load,
  output logic        ready,
  output logic        ser_data,
  output logic        frame_start,
  output logic        busy
);

  // state  | meaning
  // IDLE   | no frame, ser_data = IDLE_BIT
  // HEADER | 9 header ones
  // DATA   | 10 rows of 4 data bits + even row parity
  // COLPAR | 4 column parity bits
  // STOP   | single 0 stop bit, new ID may be accepted here
  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_COLPAR,
    S_STOP
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  bit_cnt, bit_nx;
  logic [3:0]  row_cnt, row_nx;
  logic [39:0] id_q, id_nx;
  logic [39:0] id_shift;
  logic [3:0]  nib;
  logic [3:0]  col_par;
  logic        ser_nx;
  logic        accept;

  assign ready  = (state == S_IDLE) || (state == S_STOP);
  assign accept = ready && load;

  always_comb begin
    col_par = '0;
    for (int r = 0; r < 10; r++) begin
      col_par = col_par ^ id_q[39 - 4*r -: 4];
    end
  end

  always_comb begin
    state_nx = state;
    bit_nx   = bit_cnt;
    row_nx   = row_cnt;
    id_nx    = id_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = S_HEADER;
          bit_nx   = 4'd0;
          row_nx   = 4'd0;
          id_nx    = id_data;
        end
      end
      S_HEADER: begin
        if (bit_cnt == 4'd8) begin
          state_nx = S_DATA;
          bit_nx   = 4'd0;
          row_nx   = 4'd0;
        end else begin
          bit_nx = bit_cnt + 4'd1;
        end
      end
      S_DATA: begin
        if (bit_cnt == 4'd4) begin
          bit_nx = 4'd0;
          if (row_cnt == 4'd9) begin
            state_nx = S_COLPAR;
            row_nx   = 4'd0;
          end else begin
            row_nx = row_cnt + 4'd1;
          end
        end else begin
          bit_nx = bit_cnt + 4'd1;
        end
      end
      S_COLPAR: begin
        if (bit_cnt == 4'd3) begin
          state_nx = S_STOP;
          bit_nx   = 4'd0;
          row_nx   = 4'd0;
        end else begin
          bit_nx = bit_cnt + 4'd1;
        end
      end
      S_STOP: begin
        bit_nx = 4'd0;
        row_nx = 4'd0;
        if (accept) begin
          state_nx = S_HEADER;
          id_nx    = id_data;
        end else begin
`ifdef EM4100_FRAMER_REPEAT_EN
          state_nx = S_HEADER;
`else
          state_nx = S_IDLE;
`endif
        end
      end
      default: begin
        state_nx = S_IDLE;
        bit_nx   = 4'd0;
        row_nx   = 4'd0;
      end
    endcase
  end

  // Output bit is derived from the next position so ser_data is registered with the state.
  always_comb begin
    id_shift = id_q << {row_nx, 2'b00};
    nib      = id_shift[39:36];
    ser_nx   = IDLE_BIT;
    case (state_nx)
      S_IDLE:   ser_nx = IDLE_BIT;
      S_HEADER: ser_nx = 1'b1;
      S_DATA:   ser_nx = (bit_nx == 4'd4) ? ^nib : nib[2'd3 - bit_nx[1:0]];
      S_COLPAR: ser_nx = col_par[2'd3 - bit_nx[1:0]];
      S_STOP:   ser_nx = 1'b0;
      default:  ser_nx = IDLE_BIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      bit_cnt     <= 4'd0;
      row_cnt     <= 4'd0;
      id_q        <= '0;
      ser_data    <= IDLE_BIT;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      bit_cnt     <= bit_nx;
      row_cnt     <= row_nx;
      id_q        <= id_nx;
      ser_data    <= ser_nx;
      frame_start <= (state_nx == S_HEADER) && (bit_nx == 4'd0);
      busy        <= (state_nx != S_IDLE);
    end
  end

endmodule

// File: tb/tb_em4100_framer.sv
// Directed self-checking bench for em4100_framer with hand-computed 64-bit frames.
module tb_em4100_framer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [39:0] id_data;
  logic        load;
  logic        ready, ser_data, frame_start, busy;
  int          tests = 0;
  int          fails = 0;

  localparam logic [39:0] ID80 = 40'h80_0000_0001;
  localparam logic [39:0] IDB  = 40'h12_3456_789A;
  localparam logic [63:0] EXP0  = 64'hFF80_0000_0000_0000;
  localparam logic [63:0] EXPF  = {9'h1FF, {10{5'b11110}}, 4'b0000, 1'b0};
  localparam logic [63:0] EXP80 = {9'h1FF, 5'b10001, {8{5'b00000}}, 5'b00011, 4'b1001, 1'b0};
  localparam logic [63:0] EXPB  = {9'h1FF, 4'h1, 1'b1, 4'h2, 1'b1, 4'h3, 1'b0, 4'h4, 1'b1,
                                   4'h5, 1'b0, 4'h6, 1'b0, 4'h7, 1'b1, 4'h8, 1'b1,
                                   4'h9, 1'b0, 4'hA, 1'b0, 4'b1011, 1'b0};

  em4100_framer #(.IDLE_BIT(1'b0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_data     (id_data),
    .load        (load),
    .ready       (ready),
    .ser_data    (ser_data),
    .frame_start (frame_start),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ser"}, ser_data, 1'b0);
    chk({tag, "_ready"}, ready, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_fs"}, frame_start, 1'b0);
  endtask

  task automatic start(input logic [39:0] id);
    id_data = id;
    load    = 1'b1;
  endtask

  // k = 0 edge is the accept edge; id_data is scrambled and a load is attempted mid-frame.
  task automatic check_frame(input string tag, input logic [63:0] exp, input bit chain,
                             input logic [39:0] next_id);
    for (int k = 0; k < 64; k++) begin
      @(posedge clk);
      #1;
      if (k == 0 || k == 21) load = 1'b0;
      chk($sformatf("%s_bit%0d", tag, k), ser_data, exp[63-k]);
      chk($sformatf("%s_fs%0d", tag, k), frame_start, (k == 0));
      chk($sformatf("%s_busy%0d", tag, k), busy, 1'b1);
      chk($sformatf("%s_ready%0d", tag, k), ready, (k == 63));
      if (k == 20) begin
        id_data = ~id_data;
        load    = 1'b1;
      end
      if (k == 63 && chain) begin
        id_data = next_id;
        load    = 1'b1;
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    id_data = '0;
    load    = 1'b0;
    #12;
    chk_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk_idle($sformatf("idle%0d", i));
    end

`ifdef EM4100_FRAMER_REPEAT_EN
    start(IDB);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) load = 1'b0;
      chk($sformatf("rep_bit%0d", c), ser_data, EXPB[63 - (c % 64)]);
      chk($sformatf("rep_fs%0d", c), frame_start, ((c % 64) == 0));
      chk($sformatf("rep_busy%0d", c), busy, 1'b1);
    end
`else
    start(40'h00_0000_0000);
    check_frame("zero", EXP0, 1'b0, '0);
    @(posedge clk);
    #1;
    chk_idle("after_zero");

    start(40'hFF_FFFF_FFFF);
    check_frame("ones", EXPF, 1'b0, '0);
    @(posedge clk);
    #1;
    chk_idle("after_ones");

    start(ID80);
    check_frame("id80", EXP80, 1'b1, IDB);
    check_frame("idB", EXPB, 1'b0, '0);
    @(posedge clk);
    #1;
    chk_idle("after_b2b");
    @(posedge clk);
    #1;
    chk_idle("after_b2b_2");

    start(40'h00_0000_0000);
    for (int i = 0; i < 31; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) load = 1'b0;
    end
    chk("rst_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_idle("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("rst_after");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
